ld_cell_qual: RTL and testbench



---
 rtl/seg_ld_pkg.sv | 17 +
 rtl/bal_tmr.sv | 40 ++++
 rtl/ld_cell_qual.sv | 128 ++++++++++++
 tb/tb_ld_cell_qual.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/seg_ld_pkg.sv
// Shared widths, rider-weight defaults and arithmetic helpers for the
// load-cell qualification front end.
package seg_ld_pkg;

  localparam int LD_W  = 12;
  localparam int SUM_W = 13;
  localparam int TMR_W = 26;

  localparam logic [LD_W-1:0] MIN_RIDER_WT_DFLT = 12'h200;
  localparam logic [LD_W-1:0] HYST_DFLT         = 12'h040;

  function automatic logic [LD_W-1:0] abs_diff(input logic [LD_W-1:0] a,
                                               input logic [LD_W-1:0] b);
    return (a > b) ? (a - b) : (b - a);
  endfunction

endpackage

// File: rtl/bal_tmr.sv
// Saturating qualification timer: tmr_full is set once TMR_CYCLES clocks have
// elapsed since the last clr_tmr, and held until cleared again.
module bal_tmr
  import seg_ld_pkg::*;
#(
  parameter int unsigned TMR_CYCLES = 65_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic clr_tmr,
  output logic tmr_full
);

  localparam logic [TMR_W-1:0] TERM = TMR_W'(TMR_CYCLES);

  logic [TMR_W-1:0] cnt_q, cnt_d;
  logic             full_q, full_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_tmr)
      cnt_d = '0;
    else if (cnt_q != TERM)
      cnt_d = cnt_q + TMR_W'(1);
    full_d = (cnt_d == TERM);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q  <= '0;
      full_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      full_q <= full_d;
    end
  end

  assign tmr_full = full_q;

endmodule

// File: rtl/ld_cell_qual.sv
// Load-cell front end: captures each A2D sample, registers rider-weight and
// balance flags one clock later, and overrides them when samples go stale.
module ld_cell_qual
  import seg_ld_pkg::*;
#(
  parameter logic [LD_W-1:0] MIN_RIDER_WT = MIN_RIDER_WT_DFLT,
  parameter logic [LD_W-1:0] HYST         = HYST_DFLT,
  parameter int unsigned     TMR_CYCLES   = 65_000_000,
  parameter int unsigned     DIFF_DB      = 3,
  parameter int unsigned     STALE_CYCLES = 2_500_000
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [LD_W-1:0] lft_ld,
  input  logic [LD_W-1:0] rght_ld,
  input  logic            ld_vld,
  input  logic            clr_tmr,
  output logic            sum_gt_min,
  output logic            sum_lt_min,
  output logic            diff_gt_1_4,
  output logic            diff_gt_15_16,
  output logic            tmr_full,
  output logic            ld_stale
);

  localparam int DB_W    = $clog2(DIFF_DB + 1);
  localparam int STALE_W = $clog2(STALE_CYCLES + 1);
  localparam logic [DB_W-1:0]    DB_MAX    = DB_W'(DIFF_DB);
  localparam logic [STALE_W-1:0] STALE_MAX = STALE_W'(STALE_CYCLES);
  localparam logic [SUM_W-1:0]   SUM_HI    = {1'b0, MIN_RIDER_WT} + {1'b0, HYST};
  localparam logic [SUM_W-1:0]   SUM_LO    = {1'b0, MIN_RIDER_WT} - {1'b0, HYST};

  logic [LD_W-1:0]    lft_q, lft_d, rght_q, rght_d;
  logic               s1_vld_q, s1_vld_d;
  logic               sum_gt_q, sum_gt_d, sum_lt_q, sum_lt_d;
  logic               d14_q, d14_d, d1516_q, d1516_d;
  logic [DB_W-1:0]    db_cnt_q, db_cnt_d, db_inc;
  logic [STALE_W-1:0] stale_cnt_q, stale_cnt_d;
  logic               stale_q, stale_d;
  logic [SUM_W-1:0]   sum, diff, sum_q4, sum_t;
  logic               raw_15_16;

  always_comb begin
    lft_d    = lft_q;
    rght_d   = rght_q;
    s1_vld_d = ld_vld;
    if (ld_vld) begin
      lft_d  = lft_ld;
      rght_d = rght_ld;
    end

    sum       = {1'b0, lft_q} + {1'b0, rght_q};
    diff      = {1'b0, abs_diff(lft_q, rght_q)};
    sum_q4    = sum >> 2;
    sum_t     = sum - (sum >> 4);
    raw_15_16 = (diff > sum_t);
    db_inc    = (db_cnt_q == DB_MAX) ? db_cnt_q : db_cnt_q + DB_W'(1);

    sum_gt_d = sum_gt_q;
    sum_lt_d = sum_lt_q;
    d14_d    = d14_q;
    d1516_d  = d1516_q;
    db_cnt_d = db_cnt_q;
    if (s1_vld_q) begin
      sum_gt_d = (sum > SUM_HI);
      sum_lt_d = (sum < SUM_LO);
      d14_d    = (diff > sum_q4);
      if (raw_15_16) begin
        db_cnt_d = db_inc;
        d1516_d  = (db_inc == DB_MAX);
      end else begin
        db_cnt_d = '0;
        d1516_d  = 1'b0;
      end
    end else if (stale_q) begin
      db_cnt_d = '0;
    end

    // stale clears with the flag update, so it drops together with fresh flags
    stale_cnt_d = ld_vld ? '0 :
                  (stale_cnt_q == STALE_MAX) ? stale_cnt_q : stale_cnt_q + STALE_W'(1);
    stale_d = stale_q;
    if (stale_cnt_d == STALE_MAX)
      stale_d = 1'b1;
    else if (s1_vld_q)
      stale_d = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lft_q       <= '0;
      rght_q      <= '0;
      s1_vld_q    <= 1'b0;
      sum_gt_q    <= 1'b0;
      sum_lt_q    <= 1'b1;
      d14_q       <= 1'b0;
      d1516_q     <= 1'b0;
      db_cnt_q    <= '0;
      stale_cnt_q <= '0;
      stale_q     <= 1'b0;
    end else begin
      lft_q       <= lft_d;
      rght_q      <= rght_d;
      s1_vld_q    <= s1_vld_d;
      sum_gt_q    <= sum_gt_d;
      sum_lt_q    <= sum_lt_d;
      d14_q       <= d14_d;
      d1516_q     <= d1516_d;
      db_cnt_q    <= db_cnt_d;
      stale_cnt_q <= stale_cnt_d;
      stale_q     <= stale_d;
    end
  end

  assign sum_gt_min    = sum_gt_q & ~stale_q;
  assign sum_lt_min    = sum_lt_q | stale_q;
  assign diff_gt_1_4   = d14_q & ~stale_q;
  assign diff_gt_15_16 = d1516_q & ~stale_q;
  assign ld_stale      = stale_q;

  bal_tmr #(.TMR_CYCLES(TMR_CYCLES)) u_bal_tmr (
    .clk      (clk),
    .rst      (rst),
    .clr_tmr  (clr_tmr),
    .tmr_full (tmr_full)
  );

endmodule

// File: tb/tb_ld_cell_qual.sv
// Scoreboard bench for ld_cell_qual: expected flag vectors are queued as each
// sample is driven and compared when the DUT presents the result two clocks later.
module tb_ld_cell_qual;

  localparam int TMR   = 100;
  localparam int STALE = 50;
  localparam int DB    = 3;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [11:0] lft_ld = '0, rght_ld = '0;
  logic        ld_vld = 1'b0, clr_tmr = 1'b0;
  logic        sum_gt_min, sum_lt_min, diff_gt_1_4, diff_gt_15_16, tmr_full, ld_stale;

  ld_cell_qual #(.TMR_CYCLES(TMR), .DIFF_DB(DB), .STALE_CYCLES(STALE)) dut (
    .clk(clk), .rst(rst), .lft_ld(lft_ld), .rght_ld(rght_ld), .ld_vld(ld_vld),
    .clr_tmr(clr_tmr), .sum_gt_min(sum_gt_min), .sum_lt_min(sum_lt_min),
    .diff_gt_1_4(diff_gt_1_4), .diff_gt_15_16(diff_gt_15_16),
    .tmr_full(tmr_full), .ld_stale(ld_stale)
  );

  always #5 clk = ~clk;

  // {gt, lt, d14, d1516, stale}
  wire [4:0] flags = {sum_gt_min, sum_lt_min, diff_gt_1_4, diff_gt_15_16, ld_stale};
  localparam logic [4:0] RST_FLAGS   = 5'b01000;
  localparam logic [4:0] STALE_FLAGS = 5'b01001;

  int          n_cmp = 0, n_bad = 0;
  int          m_db  = 0;
  logic [4:0]  exp_q[$];
  logic [11:0] st_l[$], st_r[$];
  logic [4:0]  e;

  task automatic drive_sample(input logic [11:0] l, input logic [11:0] r);
    logic [12:0] s, d, t;
    logic        raw;
    ld_vld  = 1'b1;
    lft_ld  = l;
    rght_ld = r;
    s   = {1'b0, l} + {1'b0, r};
    d   = (l > r) ? {1'b0, 12'(l - r)} : {1'b0, 12'(r - l)};
    t   = s - (s >> 4);
    raw = (d > t);
    m_db = raw ? ((m_db < DB) ? m_db + 1 : DB) : 0;
    exp_q.push_back({s > 13'h240, s < 13'h1C0, d > (s >> 2), raw && (m_db == DB), 1'b0});
  endtask

  task automatic test_reset();
    #1 rst = 1'b1;
    repeat (3) @(negedge clk);
    n_cmp++;
    if (flags !== RST_FLAGS) begin
      n_bad++; $display("FAIL reset_flags got %b want %b", flags, RST_FLAGS);
    end
    n_cmp++;
    if (tmr_full !== 1'b0) begin
      n_bad++; $display("FAIL reset_tmr got %b want 0", tmr_full);
    end
    rst = 1'b0;
    m_db = 0;
  endtask

  task automatic test_latency();
    @(negedge clk);
    drive_sample(12'h150, 12'h150);
    @(negedge clk);
    ld_vld = 1'b0;
    n_cmp++;
    if (flags !== RST_FLAGS) begin
      n_bad++; $display("FAIL latency_k1 got %b want %b", flags, RST_FLAGS);
    end
    @(negedge clk);
    e = exp_q.pop_front();
    n_cmp++;
    if (flags !== e) begin
      n_bad++; $display("FAIL latency_k2 got %b want %b", flags, e);
    end
    repeat (3) @(negedge clk);
    n_cmp++;
    if (flags !== e) begin
      n_bad++; $display("FAIL latency_hold got %b want %b", flags, e);
    end
  endtask

  task automatic test_thresholds();
    st_l = '{12'h100, 12'h0E0, 12'h300, 12'h120, 12'h121, 12'h0E0, 12'h140, 12'h141, 12'h150};
    st_r = '{12'h100, 12'h0DF, 12'h100, 12'h120, 12'h120, 12'h0E0, 12'h0C0, 12'h0C0, 12'h150};
    for (int j = 0; j < st_l.size() + 2; j++) begin
      @(negedge clk);
      if (j >= 2) begin
        e = exp_q.pop_front();
        n_cmp++;
        if (flags !== e) begin
          n_bad++; $display("FAIL thresh[%0d] got %b want %b", j - 2, flags, e);
        end
      end
      if (j < st_l.size()) drive_sample(st_l[j], st_r[j]);
      else ld_vld = 1'b0;
    end
  endtask

  task automatic test_back_to_back_debounce();
    st_l = '{12'h3F0, 12'h3F0, 12'h3F0, 12'h3F0, 12'h200, 12'h3F0, 12'h3F0, 12'h1F0, 12'h3F0};
    st_r = '{12'h000, 12'h000, 12'h000, 12'h000, 12'h200, 12'h000, 12'h000, 12'h010, 12'h000};
    for (int j = 0; j < st_l.size() + 2; j++) begin
      @(negedge clk);
      if (j >= 2) begin
        e = exp_q.pop_front();
        n_cmp++;
        if (flags !== e) begin
          n_bad++; $display("FAIL debounce[%0d] got %b want %b", j - 2, flags, e);
        end
      end
      if (j < st_l.size()) drive_sample(st_l[j], st_r[j]);
      else ld_vld = 1'b0;
    end
  endtask

  task automatic test_stale();
    logic [4:0] e_last;
    st_l = '{12'h200, 12'h3F0, 12'h3F0};
    st_r = '{12'h200, 12'h000, 12'h000};
    for (int j = 0; j < st_l.size() + 2; j++) begin
      @(negedge clk);
      if (j >= 2) begin
        e = exp_q.pop_front();
        n_cmp++;
        if (flags !== e) begin
          n_bad++; $display("FAIL stale_pre[%0d] got %b want %b", j - 2, flags, e);
        end
      end
      if (j < st_l.size()) drive_sample(st_l[j], st_r[j]);
      else ld_vld = 1'b0;
    end
    e_last = e;
    repeat (48) @(negedge clk);
    n_cmp++;
    if (flags !== e_last) begin
      n_bad++; $display("FAIL stale_edge49 got %b want %b", flags, e_last);
    end
    @(negedge clk);
    n_cmp++;
    if (flags !== STALE_FLAGS) begin
      n_bad++; $display("FAIL stale_assert got %b want %b", flags, STALE_FLAGS);
    end
    m_db = 0;
    repeat (5) @(negedge clk);
    drive_sample(12'h3F0, 12'h000);
    @(negedge clk);
    ld_vld = 1'b0;
    n_cmp++;
    if (flags !== STALE_FLAGS) begin
      n_bad++; $display("FAIL stale_hold_k1 got %b want %b", flags, STALE_FLAGS);
    end
    @(negedge clk);
    e = exp_q.pop_front();
    n_cmp++;
    if (flags !== e) begin
      n_bad++; $display("FAIL stale_release got %b want %b", flags, e);
    end
  endtask

  task automatic test_timer();
    @(negedge clk);
    clr_tmr = 1'b1;
    @(negedge clk);
    clr_tmr = 1'b0;
    n_cmp++;
    if (tmr_full !== 1'b0) begin
      n_bad++; $display("FAIL tmr_clr_k1 got %b want 0", tmr_full);
    end
    for (int m = 2; m <= 110; m++) begin
      @(negedge clk);
      if (m >= 100) begin
        n_cmp++;
        if (tmr_full !== (m >= 101)) begin
          n_bad++; $display("FAIL tmr_run[%0d] got %b want %b", m, tmr_full, (m >= 101));
        end
      end
    end
    clr_tmr = 1'b1;
    for (int m = 1; m <= 120; m++) begin
      @(negedge clk);
      n_cmp++;
      if (tmr_full !== 1'b0) begin
        n_bad++; $display("FAIL tmr_hold[%0d] got %b want 0", m, tmr_full);
      end
    end
    clr_tmr = 1'b0;
  endtask

  task automatic test_reset_mid();
    m_db = 0;
    st_l = '{12'h3F0, 12'h3F0, 12'h3F0};
    st_r = '{12'h000, 12'h000, 12'h000};
    for (int j = 0; j < st_l.size() + 2; j++) begin
      @(negedge clk);
      if (j >= 2) begin
        e = exp_q.pop_front();
        n_cmp++;
        if (flags !== e) begin
          n_bad++; $display("FAIL rstmid_pre[%0d] got %b want %b", j - 2, flags, e);
        end
      end
      if (j < st_l.size()) drive_sample(st_l[j], st_r[j]);
      else ld_vld = 1'b0;
    end
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    n_cmp++;
    if (flags !== RST_FLAGS || tmr_full !== 1'b0) begin
      n_bad++; $display("FAIL rstmid_async got %b/%b want %b/0", flags, tmr_full, RST_FLAGS);
    end
    @(negedge clk);
    rst = 1'b0;
    m_db = 0;
    for (int c = 1; c <= 100; c++) begin
      @(negedge clk);
      if (c == 1) drive_sample(12'h3F0, 12'h000);
      else ld_vld = 1'b0;
      if (c == 3) begin
        e = exp_q.pop_front();
        n_cmp++;
        if (flags !== e) begin
          n_bad++; $display("FAIL rstmid_db got %b want %b", flags, e);
        end
      end
      if (c >= 99) begin
        n_cmp++;
        if (tmr_full !== (c == 100)) begin
          n_bad++; $display("FAIL rstmid_tmr[%0d] got %b want %b", c, tmr_full, (c == 100));
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_latency();
    test_thresholds();
    test_back_to_back_debounce();
    test_stale();
    test_timer();
    test_reset_mid();
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_bad++; $display("FAIL scoreboard_leftover got %0d want 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
